fir_coef_loader: RTL and testbench
==================================

# fir_coef_loader

Sequencer that loads one FIR filter's coefficient RAM from a host byte stream, and drives the equalizer's coefficient-write port: address reset, MSB/LSB data, write strobe and filter select. It sits between the host register/SPI byte interface and the FIR filter bank. It enforces the bank's write spacing and byte ordering, and mutes audio processing while a load is in flight.

## Interface
- NUM_FILTERS, 4, number of filters in the bank; also the width of coef_select
- WR_SPACING, 5, minimum clk cycles between successive coefficient_wr_en pulses (≥5 required by the bank's 4-stage write-address pipeline)
- MAX_COEFS, 511, largest legal num_coefs
- clk  in  1  system clock; one clock domain
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle load request; sampled only in IDLE
- filter_idx  in  NUM_FILTERS  binary index of target filter; sampled with start
- num_coefs  in  9  coefficient count; sampled with start
- abort  in  1  cancels any load in progress
- byte_valid  in  1  host byte available
- byte_data  in  8  host byte
- byte_ready  out  1  loader accepts byte_data this cycle
- coef_addr_rst  out  1  resets the bank's coefficient write address
- coefficient_wr_en  out  1  one-cycle coefficient write strobe
- coef_select  out  NUM_FILTERS  target filter index, held for the whole load
- coef_wr_msb_data  out  8  coefficient bits [15:8]
- coef_wr_lsb_data  out  8  coefficient bits [7:0]
- audio_mute  out  1  high while loading; gates audio_en low upstream
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky fault flag; cleared by the next accepted start

## Operation
- States: IDLE, ARST, GET_MSB, GET_LSB, WRITE, GAP, CHK_MSB, CHK_LSB, FIN.
- IDLE: start=1 latches filter_idx and num_coefs, and clears error and the coefficient counter.
  - Parameter check: if num_coefs==0, num_coefs>MAX_COEFS or filter_idx≥NUM_FILTERS, set error and stay in IDLE.
  - Otherwise go to ARST.
- ARST: coef_addr_rst=1 for exactly one cycle, then GET_MSB.
- GET_MSB: byte_ready=1; on handshake (byte_valid & byte_ready), register coef_wr_msb_data and go to GET_LSB.
- GET_LSB: same handshake; register coef_wr_lsb_data and go to WRITE. MSB always precedes LSB on the stream.
- WRITE: coefficientient_wr_en=1 for one cycle, increment the coefficient counter, go to GAP.
- GAP: wait WR_SPACING−1 cycles. Then:
  - if counter==num_coefs, go to FIN (or CHK_MSB when checksum is compiled in);
  - otherwise go to GET_MSB.
- FIN: done=1 for one cycle, then IDLE.
- Data and select stability: coef_wr_msb_data, coef_wr_lsb_data and coef_select stay stable from WRITE until the next GET_MSB handshake. coef_select stays stable from ARST through FIN.
- abort=1 in any non-IDLE state: go to IDLE next cycle and set error. done does not pulse. The bank's address is left wherever it is; the next load's ARST recovers it.
- start while busy is ignored.
- byte_valid while byte_ready=0 is ignored and nothing is consumed.

## Timing
- Reset values: byte_ready, coef_addr_rst, coefficient_wr_en, audio_mute, busy, done and error are 0. coef_select and both data outputs are 0. State is IDLE.
- Reset asserted mid-load: all of the above take effect immediately (asynchronously). No partial write strobe is emitted.
- start to coef_addr_rst: 1 cycle.
- audio_mute rises in the cycle after start is accepted and falls in the cycle after FIN.
- Handshake to first write: the LSB handshake in cycle n gives coefficient_wr_en=1 in cycle n+1.
- Write spacing: successive coefficient_wr_en pulses are ≥WR_SPACING cycles apart even with byte_valid held high.
- Back-to-back throughput: exactly 2+WR_SPACING cycles per coefficient.
- The coefficient counter is 9 bits. The comparison against num_coefs is exact, so no wrap occurs (num_coefs≤511).

## Configuration
- FIR_COEF_CHECKSUM_EN defined:
  - A 16-bit running sum (modulo 2^16) of the written coefficients is kept.
  - After the last GAP, CHK_MSB and CHK_LSB each consume one byte, forming the host checksum.
  - On mismatch, error is set and done is suppressed; on match, go to FIN normally.
- Undefined: CHK states, the sum register and the trailing bytes do not exist. Exactly 2·num_coefs bytes are consumed.

## Structure
- Package fir_ctrl_pkg holds:
  - the state enum type;
  - constants WR_SPACING_DEFAULT=5 and MAX_COEFS=511;
  - the coefficient counter width (9).
- Sub-module: none. A single FSM with a counter and a gap timer.

## Test plan
- Load filter_idx=2, num_coefs=3, bytes 12 34 56 78 9A BC with byte_valid held high:
  - one coef_addr_rst;
  - three wr_en pulses with {msb,lsb}=1234, 5678, 9ABC;
  - pulses 7 cycles apart; coef_select=2 throughout;
  - done pulse, and audio_mute low 1 cycle later.
- Host stalls byte_valid for 20 cycles between MSB and LSB: no wr_en until the LSB arrives; msb output holds 8'h12.
- start with num_coefs=0, and separately with filter_idx=4: error=1, busy stays 0, no strobes.
- abort asserted in GAP after the 2nd of 5 coefficients: IDLE next cycle, error=1, no done. A following start clears error and reissues coef_addr_rst.
- Checksum (with FIR_COEF_CHECKSUM_EN) on coefficients 0001, 0002:
  - trailing bytes 00 03 give done;
  - trailing bytes 00 04 give error=1 and no done.
- reset_n pulsed low mid-GET_LSB: all outputs drop to 0 asynchronously; after release, state is IDLE.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient loader.
// State encoding, write spacing default and coefficient counter width.
package fir_ctrl_pkg;

  localparam int WR_SPACING_DEFAULT = 5;
  localparam int MAX_COEFS          = 511;
  localparam int CNT_W              = 9;

  typedef enum logic [3:0] {
    IDLE,
    ARST,
    GET_MSB,
    GET_LSB,
    WRITE,
    GAP,
    CHK_MSB,
    CHK_LSB,
    FIN
  } state_t;

endpackage

// File: rtl/fir_coef_loader.sv
// Loads one FIR filter's coefficient RAM from a host byte stream.
// Optional trailing host checksum check: define FIR_COEF_CHECKSUM_EN.
module fir_coef_loader
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_FILTERS = 4,
  parameter int WR_SPACING  = WR_SPACING_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [NUM_FILTERS-1:0] filter_idx,
  input  logic [CNT_W-1:0]       num_coefs,
  input  logic                   abort,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   coef_addr_rst,
  output logic                   coefficient_wr_en,
  output logic [NUM_FILTERS-1:0] coef_select,
  output logic [7:0]             coef_wr_msb_data,
  output logic [7:0]             coef_wr_lsb_data,
  output logic                   audio_mute,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int GAP_W = $clog2(WR_SPACING);
  localparam logic [GAP_W-1:0] GAP_END =
    GAP_W'(WR_SPACING - 2);
  localparam logic [CNT_W:0] MAX_EXT =
    (CNT_W + 1)'(MAX_COEFS);
  localparam logic [NUM_FILTERS-1:0] NF =
    NUM_FILTERS'(NUM_FILTERS);

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_coefs;
  logic [GAP_W-1:0] gap;
  logic             hs;
  logic             params_ok;
  logic             gap_last;
  logic             last;
  logic             fin;
  logic             chk_ok;
  logic             go;

`ifdef FIR_COEF_CHECKSUM_EN
  logic [15:0] sum;
  logic [7:0]  chk_hi;
  assign chk_ok = {chk_hi, byte_data} == sum;
`else
  assign chk_ok = 1'b1;
`endif

  assign hs        = byte_valid & byte_ready;
  assign gap_last  = gap == GAP_END;
  assign last      = cnt == n_coefs;
  assign go        = (state == IDLE) & start;
  assign params_ok = (num_coefs != '0)
                   & ({1'b0, num_coefs} <= MAX_EXT)
                   & (filter_idx < NF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort && state != IDLE) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start && params_ok) state_nx = ARST;
        ARST:    state_nx = GET_MSB;
        GET_MSB: if (hs) state_nx = GET_LSB;
        GET_LSB: if (hs) state_nx = WRITE;
        WRITE:   state_nx = GAP;
        GAP: begin
          if (gap_last) begin
`ifdef FIR_COEF_CHECKSUM_EN
            state_nx = last ? CHK_MSB : GET_MSB;
`else
            state_nx = last ? FIN : GET_MSB;
`endif
          end
        end
        CHK_MSB: if (hs) state_nx = CHK_LSB;
        CHK_LSB: if (hs) state_nx = chk_ok ? FIN : IDLE;
        FIN:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    byte_ready        = 1'b0;
    coef_addr_rst     = 1'b0;
    coefficient_wr_en = 1'b0;
    fin               = 1'b0;
    unique case (state)
      ARST:    coef_addr_rst = 1'b1;
      GET_MSB,
      GET_LSB,
      CHK_MSB,
      CHK_LSB: byte_ready = 1'b1;
      WRITE:   coefficient_wr_en = 1'b1;
      FIN:     fin = 1'b1;
      default: ;
    endcase
  end

  assign busy       = state != IDLE;
  assign audio_mute = busy;
  // an abort landing on FIN still counts as a cancelled load
  assign done       = fin & ~abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt              <= '0;
      n_coefs          <= '0;
      gap              <= '0;
      coef_select      <= '0;
      coef_wr_msb_data <= '0;
      coef_wr_lsb_data <= '0;
      error            <= 1'b0;
`ifdef FIR_COEF_CHECKSUM_EN
      sum              <= '0;
      chk_hi           <= '0;
`endif
    end else begin
      if (go) begin
        error <= ~params_ok;
        cnt   <= '0;
`ifdef FIR_COEF_CHECKSUM_EN
        sum   <= '0;
`endif
        if (params_ok) begin
          n_coefs     <= num_coefs;
          coef_select <= filter_idx;
        end
      end
      if (state == GET_MSB && hs)
        coef_wr_msb_data <= byte_data;
      if (state == GET_LSB && hs)
        coef_wr_lsb_data <= byte_data;
      if (state == WRITE) begin
        cnt <= cnt + CNT_W'(1);
`ifdef FIR_COEF_CHECKSUM_EN
        sum <= sum + {coef_wr_msb_data,
                      coef_wr_lsb_data};
`endif
      end
      gap <= (state == GAP) ? gap + GAP_W'(1) : '0;
`ifdef FIR_COEF_CHECKSUM_EN
      if (state == CHK_MSB && hs)
        chk_hi <= byte_data;
`endif
      if (state == CHK_LSB && hs && !chk_ok)
        error <= 1'b1;
      if (abort && state != IDLE)
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed self-checking bench for fir_coef_loader.
// Checksum steps run only when FIR_COEF_CHECKSUM_EN is defined.
module tb_fir_coef_loader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] filter_idx = '0;
  logic [8:0] num_coefs = '0;
  logic       abort = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic       byte_ready;
  logic       coef_addr_rst;
  logic       coefficient_wr_en;
  logic [3:0] coef_select;
  logic [7:0] coef_wr_msb_data;
  logic [7:0] coef_wr_lsb_data;
  logic       audio_mute;
  logic       busy;
  logic       done;
  logic       error;

  fir_coef_loader dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .filter_idx        (filter_idx),
    .num_coefs         (num_coefs),
    .abort             (abort),
    .byte_valid        (byte_valid),
    .byte_data         (byte_data),
    .byte_ready        (byte_ready),
    .coef_addr_rst     (coef_addr_rst),
    .coefficient_wr_en (coefficient_wr_en),
    .coef_select       (coef_select),
    .coef_wr_msb_data  (coef_wr_msb_data),
    .coef_wr_lsb_data  (coef_wr_lsb_data),
    .audio_mute        (audio_mute),
    .busy              (busy),
    .done              (done),
    .error             (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int         wr_n, arst_n, done_n, busy_cnt;
  int         rst_cyc, start_cyc, done_cyc;
  logic       mute_after, done_prev;
  logic [15:0] wr_data [16];
  int          wr_cyc  [16];
  logic [3:0]  wr_sel  [16];

  logic [7:0] stream [16];
  int         len, ptr, stall_at, stall_left;
  bit         feed_en, feed_hs;

  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (coefficient_wr_en && wr_n < 16) begin
        wr_data[wr_n] = {coef_wr_msb_data, coef_wr_lsb_data};
        wr_cyc[wr_n]  = cyc;
        wr_sel[wr_n]  = coef_select;
        wr_n++;
      end
      if (coef_addr_rst) begin
        arst_n++;
        rst_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (done_prev) mute_after = audio_mute;
      done_prev = done;
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (start && !busy) start_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (feed_hs) ptr++;
    byte_data = (ptr < len) ? stream[ptr] : 8'h00;
    if (feed_en && ptr < len) begin
      if (ptr == stall_at && stall_left > 0) begin
        byte_valid = 1'b0;
        stall_left--;
      end else begin
        byte_valid = 1'b1;
      end
    end else begin
      byte_valid = 1'b0;
    end
    feed_hs = byte_valid && byte_ready;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wr_n = 0; arst_n = 0; done_n = 0; busy_cnt = 0;
    ptr = 0; len = 0; feed_hs = 0;
    stall_at = -1; stall_left = 0;
    mute_after = 1'b1; done_prev = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] idx,
                          input logic [8:0] n);
    filter_idx = idx;
    num_coefs  = n;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int k = 0;
    while (done_n == 0 && k < maxc) begin
      tick(1);
      k++;
    end
  endtask

  initial begin
    clr();
    feed_en = 1'b0;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_mute", audio_mute, 0);
    chk("rst_error", error, 0);
    chk("rst_sel", coef_select, 0);
    chk("rst_msb", coef_wr_msb_data, 0);
    chk("rst_strobes",
        {coef_addr_rst, coefficient_wr_en, done}, 0);
    reset_n = 1'b1;
    tick(2);

    // basic three-coefficient load, byte_valid held high
    clr();
    stream[0] = 8'h12; stream[1] = 8'h34;
    stream[2] = 8'h56; stream[3] = 8'h78;
    stream[4] = 8'h9A; stream[5] = 8'hBC;
    len = 6;
    feed_en = 1'b1;
    do_start(4'd2, 9'd3);
    wait_done(100);
    tick(2);
    chk("t1_arst_cnt", arst_n, 1);
    chk("t1_arst_lat", rst_cyc - start_cyc, 1);
    chk("t1_wr_cnt", wr_n, 3);
    chk("t1_wr0", wr_data[0], 16'h1234);
    chk("t1_wr1", wr_data[1], 16'h5678);
    chk("t1_wr2", wr_data[2], 16'h9ABC);
    chk("t1_first_wr", wr_cyc[0] - rst_cyc, 3);
    chk("t1_space01", wr_cyc[1] - wr_cyc[0], 7);
    chk("t1_space12", wr_cyc[2] - wr_cyc[1], 7);
    chk("t1_sel0", wr_sel[0], 2);
    chk("t1_sel2", wr_sel[2], 2);
    chk("t1_done_cnt", done_n, 1);
    chk("t1_done_lat", done_cyc - wr_cyc[2], 5);
    chk("t1_mute_after", mute_after, 0);
    chk("t1_consumed", ptr, 6);
    chk("t1_error", error, 0);
    chk("t1_busy", busy, 0);

    // host stalls 20 cycles between MSB and LSB
    clr();
    stream[0] = 8'h12; stream[1] = 8'h34;
    len = 2;
    stall_at = 1; stall_left = 20;
    do_start(4'd1, 9'd1);
    tick(10);
    chk("t2_no_wr", wr_n, 0);
    chk("t2_msb_hold", coef_wr_msb_data, 8'h12);
    chk("t2_ready", byte_ready, 1);
    chk("t2_busy", busy, 1);
    wait_done(60);
    tick(2);
    chk("t2_wr_cnt", wr_n, 1);
    chk("t2_wr0", wr_data[0], 16'h1234);
    chk("t2_wr_lat", wr_cyc[0] - rst_cyc, 23);
    chk("t2_sel", wr_sel[0], 1);
    chk("t2_done", done_n, 1);

    // rejected parameters
    clr();
    feed_en = 1'b0;
    do_start(4'd0, 9'd0);
    tick(3);
    chk("t3_n0_error", error, 1);
    chk("t3_n0_busy", busy_cnt, 0);
    chk("t3_n0_arst", arst_n, 0);
    do_start(4'd4, 9'd3);
    tick(3);
    chk("t3_f4_error", error, 1);
    chk("t3_f4_busy", busy_cnt, 0);
    chk("t3_f4_strobes", arst_n + wr_n + done_n, 0);
    do_start(4'd3, 9'd511);
    chk("t3_max_busy", busy, 1);
    chk("t3_max_err_clr", error, 0);
    chk("t3_max_arst", coef_addr_rst, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t3_abort_idle", busy, 0);
    chk("t3_abort_err", error, 1);
    chk("t3_abort_sel", coef_select, 3);

    // abort in GAP after the 2nd of 5 coefficients
    clr();
    for (int i = 0; i < 10; i++) stream[i] = 8'(i + 1);
    len = 10;
    feed_en = 1'b1;
    do_start(4'd0, 9'd5);
    begin
      int k = 0;
      while (wr_n < 2 && k < 100) begin
        tick(1);
        k++;
      end
    end
    chk("t4_reach_2", wr_n, 2);
    chk("t4_in_gap",
        {busy, byte_ready, coefficient_wr_en}, 3'b100);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t4_idle", busy, 0);
    chk("t4_error", error, 1);
    tick(20);
    chk("t4_no_done", done_n, 0);
    chk("t4_wr_cnt", wr_n, 2);
    chk("t4_wr1", wr_data[1], 16'h0304);
    ptr = 0; feed_hs = 0;
    stream[0] = 8'hAB; stream[1] = 8'hCD;
    len = 2;
    do_start(4'd1, 9'd1);
    chk("t4_err_clr", error, 0);
    chk("t4_rearst", coef_addr_rst, 1);
    wait_done(60);
    tick(2);
    chk("t4_arst_cnt", arst_n, 2);
    chk("t4_wr_new", wr_data[2], 16'hABCD);
    chk("t4_done", done_n, 1);

    // asynchronous reset while waiting for the LSB
    clr();
    stream[0] = 8'h55; stream[1] = 8'h66;
    stream[2] = 8'h77; stream[3] = 8'h88;
    len = 4;
    stall_at = 1; stall_left = 50;
    do_start(4'd3, 9'd2);
    tick(5);
    chk("t5_pre_ready", byte_ready, 1);
    chk("t5_pre_msb", coef_wr_msb_data, 8'h55);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_ready", byte_ready, 0);
    chk("t5_mute", audio_mute, 0);
    chk("t5_sel", coef_select, 0);
    chk("t5_msb", coef_wr_msb_data, 0);
    chk("t5_strobes",
        {coef_addr_rst, coefficient_wr_en, done, error}, 0);
    tick(2);
    reset_n = 1'b1;
    feed_en = 1'b0;
    tick(3);
    chk("t5_idle", busy, 0);
    chk("t5_no_wr", wr_n, 0);
    chk("t5_no_done", done_n, 0);

`ifdef FIR_COEF_CHECKSUM_EN
    clr();
    stream[0] = 8'h00; stream[1] = 8'h01;
    stream[2] = 8'h00; stream[3] = 8'h02;
    stream[4] = 8'h00; stream[5] = 8'h03;
    len = 6;
    feed_en = 1'b1;
    do_start(4'd0, 9'd2);
    wait_done(80);
    tick(2);
    chk("cs_ok_done", done_n, 1);
    chk("cs_ok_err", error, 0);
    chk("cs_ok_bytes", ptr, 6);
    clr();
    stream[5] = 8'h04;
    len = 6;
    do_start(4'd0, 9'd2);
    tick(40);
    chk("cs_bad_done", done_n, 0);
    chk("cs_bad_err", error, 1);
    chk("cs_bad_busy", busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
